stream_rr_arbiter: RTL and testbench



---
 rtl/stream_rr_arbiter.sv | 115 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: N_SRC source streams share one registered
// output beat; grant is held for a whole packet, then the pointer moves past the winner.

module stream_rr_arbiter_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            busy_i,
  input  logic [ID_W-1:0] grant_i,
  input  logic            take_ok_i,
  output logic            ready_o
);
  assign ready_o = busy_i && take_ok_i && (grant_i == ID_W'(IDX));
endmodule

module stream_rr_arbiter #(
  parameter  int T_DATA_WIDTH = 4,
  parameter  int N_SRC        = 4,
  localparam int ID_W         = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC-1:0],
  input  logic [N_SRC-1:0]        s_last_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [ID_W-1:0]         m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic                    last;
    logic [ID_W-1:0]         id;
    logic [T_DATA_WIDTH-1:0] data;
  } beat_t;

  localparam logic [ID_W:0]   N_W      = (ID_W+1)'(N_SRC);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SRC - 1);

  state_e          state_q;
  logic [ID_W-1:0] grant_q, rr_ptr_q, rr_ptr_d, pick;
  logic [ID_W:0]   scan;
  logic            found, take_ok, accept;
  beat_t           out_q;
  logic            out_vld_q;

  // The output slot can take a beat if it is empty or being drained this cycle.
  assign take_ok = m_ready_i || !out_vld_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_lane
    stream_rr_arbiter_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
      .busy_i    (state_q == BUSY),
      .grant_i   (grant_q),
      .take_ok_i (take_ok),
      .ready_o   (s_ready_o[i])
    );
  end

  assign accept   = s_valid_i[grant_q] && s_ready_o[grant_q];
  assign rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at N_SRC; the extra bit keeps the sum exact.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= N_W) scan = scan - N_W;
      if (!found && s_valid_i[scan[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        out_q     <= '{last: s_last_i[grant_q], id: grant_q, data: s_data_i[grant_q]};
        out_vld_q <= 1'b1;
      end else if (m_ready_i) begin
        out_vld_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (found) begin
          grant_q <= pick;
          state_q <= BUSY;
        end
        BUSY: if (accept && s_last_i[grant_q]) begin
          state_q  <= IDLE;
          rr_ptr_q <= rr_ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data_o  = out_q.data;
  assign m_id_o    = out_q.id;
  assign m_last_o  = out_q.last;
  assign m_valid_o = out_vld_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: per-source packet queues feed the DUT, and a
// packet-level reference model predicts ready and the registered output each cycle.

module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] s_data [N-1:0];
  logic [N-1:0]  s_last, s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    m_id;
  logic          m_last, m_valid, m_ready;

  logic [3:0] s3_data [2:0];
  logic [2:0] s3_last, s3_valid, s3_ready;
  logic [3:0] m3_data;
  logic [1:0] m3_id;
  logic       m3_last, m3_valid, m3_ready;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.T_DATA_WIDTH(DW), .N_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .m_data_o(m_data), .m_id_o(m_id), .m_last_o(m_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready));

  stream_rr_arbiter #(.T_DATA_WIDTH(4), .N_SRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_data_i(s3_data), .s_last_i(s3_last), .s_valid_i(s3_valid),
    .s_ready_o(s3_ready), .m_data_o(m3_data), .m_id_o(m3_id), .m_last_o(m3_last),
    .m_valid_o(m3_valid), .m_ready_i(m3_ready));

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; logic l; int id; } obs_t;

  beat_t        srcq [N][$];
  obs_t         out_log [$];
  logic [N-1:0] stall;
  logic         mrdy;

  // reference model state: packet owner, fairness pointer, expected output slot
  bit            mdl_busy;
  int            mdl_gnt, mdl_ptr, exp_id;
  logic          exp_v, exp_l;
  logic [DW-1:0] exp_d;
  logic [N-1:0]  want_rdy, obs_rdy;

  int tests_run = 0, tests_failed = 0;

  function automatic bit pending();
    bit p = 1'b0;
    for (int s = 0; s < N; s++) if (srcq[s].size() > 0) p = 1'b1;
    return p || exp_v || mdl_busy;
  endfunction

  task automatic model_reset();
    mdl_busy = 0; mdl_gnt = 0; mdl_ptr = 0;
    exp_v = 0; exp_l = 0; exp_d = '0; exp_id = 0;
    for (int s = 0; s < N; s++) srcq[s].delete();
    out_log.delete();
    stall = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive sources from their queues, log the output handshake,
  // advance the model by the arbitration rules, then move past the edge.
  task automatic step();
    beat_t b;
    obs_t  o;
    bit    acc;
    int    best, bestd, d;
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      s_valid[s] = (srcq[s].size() > 0) && !stall[s];
      s_data[s]  = (srcq[s].size() > 0) ? srcq[s][0].d : '0;
      s_last[s]  = (srcq[s].size() > 0) ? srcq[s][0].l : 1'b0;
    end
    m_ready = mrdy;
    #1;
    obs_rdy = s_ready;
    if (m_valid && m_ready) begin
      o.d = m_data; o.l = m_last; o.id = int'(m_id);
      out_log.push_back(o);
    end
    want_rdy = (mdl_busy && (mrdy || !exp_v)) ? (N'(1) << mdl_gnt) : '0;
    acc = mdl_busy && s_valid[mdl_gnt] && (mrdy || !exp_v);
    if (acc) begin
      b = srcq[mdl_gnt].pop_front();
      exp_v = 1'b1; exp_d = b.d; exp_l = b.l; exp_id = mdl_gnt;
    end else if (mrdy) begin
      exp_v = 1'b0;
    end
    if (!mdl_busy) begin
      best = -1; bestd = N;
      for (int s = 0; s < N; s++) begin
        d = (s - mdl_ptr + N) % N;
        if (s_valid[s] && d < bestd) begin best = s; bestd = d; end
      end
      if (best >= 0) begin mdl_busy = 1; mdl_gnt = best; end
    end else if (acc && b.l) begin
      mdl_busy = 0;
      mdl_ptr  = (mdl_gnt + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = '1; s_last = '1;
    for (int s = 0; s < N; s++) s_data[s] = 8'hA5;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || m_id !== '0) begin
      tests_failed++;
      $display("FAIL reset_out got v=%b l=%b d=%h id=%0d want all 0", m_valid, m_last, m_data, m_id);
    end
    tests_run++;
    if (s_ready !== '0) begin
      tests_failed++;
      $display("FAIL reset_ready got %b want 0000", s_ready);
    end
    s_valid = '0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    logic [DW-1:0] a, b, c;
    a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
    apply_reset();
    mrdy = 1'b1;
    srcq[2].push_back('{a, 1'b0});
    srcq[2].push_back('{b, 1'b0});
    srcq[2].push_back('{c, 1'b1});
    for (int cyc = 0; cyc < 40 && pending(); cyc++) begin
      step();
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL single ready got %b want %b", obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL single out got v=%b d=%h l=%b id=%0d want v=%b d=%h l=%b id=%0d",
                 m_valid, m_data, m_last, m_id, exp_v, exp_d, exp_l, exp_id);
      end
    end
    tests_run++;
    if (out_log.size() != 3 || out_log[0].d !== a || out_log[1].d !== b || out_log[2].d !== c ||
        out_log[0].id != 2 || out_log[2].id != 2 || out_log[0].l || out_log[1].l || !out_log[2].l) begin
      tests_failed++;
      $display("FAIL single_seq got %0d beats want A,B,C from src2 with last on C", out_log.size());
    end
  endtask

  // runs straight after test_single_source: pointer sits at 3
  task automatic test_wrap();
    for (int ph = 0; ph < 2; ph++) begin
      out_log.delete();
      if (ph == 0) begin
        srcq[1].push_back('{8'h11, 1'b0}); srcq[1].push_back('{8'h12, 1'b1});
        srcq[3].push_back('{8'h31, 1'b0}); srcq[3].push_back('{8'h32, 1'b1});
      end else begin
        srcq[0].push_back('{8'h01, 1'b1});
        srcq[2].push_back('{8'h21, 1'b1});
      end
      for (int cyc = 0; cyc < 40 && pending(); cyc++) begin
        step();
        tests_run++;
        if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL wrap ready got %b want %b", obs_rdy, want_rdy); end
        tests_run++;
        if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
          tests_failed++;
          $display("FAIL wrap out got v=%b d=%h id=%0d want v=%b d=%h id=%0d", m_valid, m_data, m_id, exp_v, exp_d, exp_id);
        end
      end
      tests_run++;
      if (ph == 0 && (out_log.size() != 4 || out_log[0].id != 3 || out_log[1].id != 3 || out_log[2].id != 1 || out_log[3].id != 1)) begin
        tests_failed++;
        $display("FAIL wrap_order got %0d beats first id %0d want 3,3,1,1", out_log.size(), out_log.size() ? out_log[0].id : -1);
      end else if (ph == 1 && (out_log.size() != 2 || out_log[0].id != 2 || out_log[1].id != 0)) begin
        tests_failed++;
        $display("FAIL wrap_ptr got %0d beats first id %0d want 2,0", out_log.size(), out_log.size() ? out_log[0].id : -1);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    mrdy = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) begin
        srcq[s].push_back('{DW'($urandom), 1'b0});
        srcq[s].push_back('{DW'($urandom), 1'b1});
      end
    for (int cyc = 0; cyc < 100 && pending(); cyc++) begin
      step();
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL fair ready got %b want %b", obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL fair out got v=%b d=%h id=%0d want v=%b d=%h id=%0d", m_valid, m_data, m_id, exp_v, exp_d, exp_id);
      end
    end
    tests_run++;
    if (out_log.size() != 16) begin tests_failed++; $display("FAIL fair_count got %0d want 16", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 16; i++) begin
      tests_run++;
      if (out_log[i].id != (i / 2) % N) begin
        tests_failed++;
        $display("FAIL fair_order beat %0d got id %0d want %0d", i, out_log[i].id, (i / 2) % N);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [4];
    logic [DW-1:0] held;
    int hold = -1;
    apply_reset();
    mrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d[i] = DW'($urandom);
      srcq[0].push_back('{d[i], i == 3});
    end
    for (int cyc = 0; cyc < 60 && pending(); cyc++) begin
      if (hold < 0 && out_log.size() == 2) begin hold = 5; held = m_data; end
      mrdy = !(hold > 0);
      step();
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL bp ready got %b want %b", obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL bp out got v=%b d=%h want v=%b d=%h", m_valid, m_data, exp_v, exp_d);
      end
      if (hold > 0) begin
        hold--;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== held || s_ready !== '0) begin
          tests_failed++;
          $display("FAIL bp_hold got v=%b d=%h rdy=%b want v=1 d=%h rdy=0000", m_valid, m_data, s_ready, held);
        end
      end
    end
    mrdy = 1'b1;
    tests_run++;
    if (out_log.size() != 4 || out_log[0].d !== d[0] || out_log[1].d !== d[1] ||
        out_log[2].d !== d[2] || out_log[3].d !== d[3] || !out_log[3].l) begin
      tests_failed++;
      $display("FAIL bp_seq got %0d beats want 4 in order", out_log.size());
    end
  endtask

  task automatic test_stall();
    int st = -1;
    int want [8] = '{0, 0, 0, 0, 1, 1, 2, 2};
    apply_reset();
    mrdy = 1'b1;
    for (int i = 0; i < 4; i++) srcq[0].push_back('{DW'(8'h40 + i), i == 3});
    for (int s = 1; s < 3; s++) begin
      srcq[s].push_back('{DW'(s * 16), 1'b0});
      srcq[s].push_back('{DW'(s * 16 + 1), 1'b1});
    end
    for (int cyc = 0; cyc < 80 && pending(); cyc++) begin
      if (st < 0 && out_log.size() >= 1) st = 3;
      stall[0] = (st > 0);
      step();
      if (st > 0) st--;
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL stall ready got %b want %b", obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL stall out got v=%b d=%h id=%0d want v=%b d=%h id=%0d", m_valid, m_data, m_id, exp_v, exp_d, exp_id);
      end
    end
    tests_run++;
    if (out_log.size() != 8) begin tests_failed++; $display("FAIL stall_count got %0d want 8", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 8; i++) begin
      tests_run++;
      if (out_log[i].id != want[i]) begin
        tests_failed++;
        $display("FAIL stall_order beat %0d got id %0d want %0d", i, out_log[i].id, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    mrdy = 1'b1;
    for (int i = 0; i < 4; i++) srcq[1].push_back('{DW'(8'h90 + i), i == 3});
    for (int cyc = 0; cyc < 20 && out_log.size() < 2; cyc++) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || s_ready !== '0) begin
      tests_failed++;
      $display("FAIL rst_async got v=%b rdy=%b want v=0 rdy=0000", m_valid, s_ready);
    end
    model_reset();
    s_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    srcq[3].push_back('{8'h33, 1'b1});
    srcq[2].push_back('{8'h22, 1'b1});
    for (int cyc = 0; cyc < 40 && pending(); cyc++) begin
      step();
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL rstmid ready got %b want %b", obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL rstmid out got v=%b d=%h id=%0d want v=%b d=%h id=%0d", m_valid, m_data, m_id, exp_v, exp_d, exp_id);
      end
    end
    tests_run++;
    if (out_log.size() != 2 || out_log[0].id != 2 || out_log[1].id != 3) begin
      tests_failed++;
      $display("FAIL rstmid_order got %0d beats first id %0d want 2,3", out_log.size(), out_log.size() ? out_log[0].id : -1);
    end
  endtask

  task automatic test_random();
    int total = 0, len;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 400) begin
        for (int s = 0; s < N; s++)
          if (srcq[s].size() == 0 && $urandom_range(0, 3) == 0) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) srcq[s].push_back('{DW'($urandom), i == len - 1});
            total += len;
          end
        stall = N'($urandom) & N'($urandom);
        mrdy  = ($urandom_range(0, 3) != 0);
      end else begin
        stall = '0;
        mrdy  = 1'b1;
        if (!pending()) break;
      end
      step();
      tests_run++;
      if (obs_rdy !== want_rdy) begin tests_failed++; $display("FAIL rand ready cyc %0d got %b want %b", cyc, obs_rdy, want_rdy); end
      tests_run++;
      if (m_valid !== exp_v || (exp_v && (m_data !== exp_d || m_last !== exp_l || m_id !== 2'(exp_id)))) begin
        tests_failed++;
        $display("FAIL rand out cyc %0d got v=%b d=%h l=%b id=%0d want v=%b d=%h l=%b id=%0d",
                 cyc, m_valid, m_data, m_last, m_id, exp_v, exp_d, exp_l, exp_id);
      end
    end
    tests_run++;
    if (pending() || out_log.size() != total) begin
      tests_failed++;
      $display("FAIL rand_count got %0d beats want %0d", out_log.size(), total);
    end
  endtask

  // three sources, all sending single-beat packets: order must be 0,1,2,0,1,2
  task automatic test_nonpow2();
    int ids [$];
    logic [3:0] dats [$];
    apply_reset();
    s3_valid = 3'b111;
    for (int cyc = 0; cyc < 30 && ids.size() < 6; cyc++) begin
      @(posedge clk);
      #1;
      if (m3_valid) begin ids.push_back(int'(m3_id)); dats.push_back(m3_data); end
    end
    s3_valid = '0;
    tests_run++;
    if (ids.size() != 6) begin tests_failed++; $display("FAIL np2_count got %0d want 6", ids.size()); end
    for (int i = 0; i < ids.size(); i++) begin
      tests_run++;
      if (ids[i] != i % 3 || dats[i] != 4'(i % 3)) begin
        tests_failed++;
        $display("FAIL np2_order beat %0d got id %0d d %0d want %0d", i, ids[i], dats[i], i % 3);
      end
    end
  endtask

  initial begin
    s_valid = '0; s_last = '0; m_ready = 1'b1; mrdy = 1'b1; stall = '0;
    for (int s = 0; s < N; s++) s_data[s] = '0;
    for (int s = 0; s < 3; s++) s3_data[s] = 4'(s);
    s3_last = 3'b111; s3_valid = '0; m3_ready = 1'b1;
    model_reset();
    test_reset();
    test_single_source();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_stall();
    test_reset_mid_packet();
    test_random();
    test_nonpow2();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
